// File: rtl/font_rom_arbiter_if.sv
// Bundle between the text-overlay generators / font ROM and the font ROM arbiter.
// Latency: none, this is wiring only.
// Backpressure: none, the arbiter accepts one pixel per clock unconditionally.
interface font_rom_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_on;
    logic [11*NREQ-1:0] req_rom_addr;
    logic [3*NREQ-1:0]  req_bit_addr;
    logic [NREQ-1:0]    blink_en;
    logic               frame_tick;
    logic               conflict_clr;
    logic [10:0]        rom_addr;
    logic [7:0]         rom_data;
    logic               text_on;
    logic [2:0]         text_src;
    logic [15:0]        conflict_cnt;

    // Generator/ROM side: drives requests, controls and ROM data.
    modport master (
        output req_on, req_rom_addr, req_bit_addr, blink_en,
        output frame_tick, conflict_clr, rom_data,
        input  rom_addr, text_on, text_src, conflict_cnt
    );

    // Arbiter side.
    modport slave (
        input  req_on, req_rom_addr, req_bit_addr, blink_en,
        input  frame_tick, conflict_clr, rom_data,
        output rom_addr, text_on, text_src, conflict_cnt
    );
endinterface

// File: rtl/font_rom_arbiter.sv
// Fixed-priority share of one font ROM among NREQ text generators, with blink and conflict debug counter.
// Latency: ROM_LAT+2 clocks from req_* to text_on/text_src.
// Backpressure: none, one pixel per clock; losing requesters are simply not drawn.
module font_rom_arbiter #(
    parameter int NREQ         = 3,
    parameter int ROM_LAT      = 1,
    parameter int BLINK_FRAMES = 30
) (
    input logic              clk,
    input logic              rst,
    font_rom_arbiter_if.slave bus
);
    localparam int CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int LAST = ROM_LAT - 1;

    logic [CW-1:0]   blink_cnt;
    logic            phase;
    logic [NREQ-1:0] eff;
    logic [2:0]      g;
    logic [10:0]     sel_addr;
    logic [2:0]      sel_bit;
    logic            any_req;
    logic            conflict;
    int              n_req;

    logic            va;
    logic [2:0]      ga;
    logic [2:0]      ba;
    logic [ROM_LAT-1:0] vd;
    logic [2:0]      gd [ROM_LAT];
    logic [2:0]      bd [ROM_LAT];

    // Effective requests: blinked-off requesters leave arbitration and conflict counting.
    always_comb begin
        eff = bus.req_on & (~bus.blink_en | {NREQ{phase}});
    end

    // Fixed priority grant: scan high to low so the lowest requesting index wins.
    always_comb begin
        g        = 3'd0;
        sel_addr = 11'd0;
        sel_bit  = 3'd0;
        n_req    = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (eff[i]) begin
                g        = 3'(i);
                sel_addr = bus.req_rom_addr[11*i +: 11];
                sel_bit  = bus.req_bit_addr[3*i +: 3];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            n_req = n_req + int'(eff[i]);
        end
        any_req  = |eff;
        conflict = (n_req >= 2);
    end

    // Blink timer: phase toggles every BLINK_FRAMES frame ticks, starts visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (bus.frame_tick) begin
            if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Stage A: register ROM address (held when idle) and the granted pixel metadata.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rom_addr <= 11'd0;
            va           <= 1'b0;
            ga           <= 3'd0;
            ba           <= 3'd0;
        end else begin
            if (any_req) begin
                bus.rom_addr <= sel_addr;
            end
            va <= any_req;
            ga <= g;
            ba <= sel_bit;
        end
    end

    // Metadata delay line so it lines up with rom_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vd <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                gd[i] <= 3'd0;
                bd[i] <= 3'd0;
            end
        end else begin
            vd[0] <= va;
            gd[0] <= ga;
            bd[0] <= ba;
            for (int i = 1; i < ROM_LAT; i++) begin
                vd[i] <= vd[i-1];
                gd[i] <= gd[i-1];
                bd[i] <= bd[i-1];
            end
        end
    end

    // Output stage: pick the glyph column bit, column 0 is the row byte's MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.text_on  <= 1'b0;
            bus.text_src <= 3'd0;
        end else begin
            bus.text_on  <= vd[LAST] & bus.rom_data[3'd7 - bd[LAST]];
            bus.text_src <= vd[LAST] ? gd[LAST] : 3'd0;
        end
    end

    // Saturating conflict counter; clear wins over a simultaneous increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.conflict_cnt <= 16'd0;
        end else if (bus.conflict_clr) begin
            bus.conflict_cnt <= 16'd0;
        end else if (conflict && (bus.conflict_cnt != 16'hFFFF)) begin
            bus.conflict_cnt <= bus.conflict_cnt + 16'd1;
        end
    end
endmodule
